// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: FIFO-buffered 8N1 UART transmitter fed by an output-port write strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module out_port_uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 fifo_full,
    output logic                 overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t                 r_state, w_next;
    logic [BW-1:0]          r_baud;
    logic [NW-1:0]          r_bit, w_bit_next;
    logic [DATA_BITS-1:0]   r_data;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count, w_count_next;
    logic                   r_tx, r_busy, r_full, r_overflow;
    logic                   w_tick, w_push, w_pop, w_tx_next, w_busy_next;

    // A pop never frees room for a write in the same cycle: full is judged on the old count.
    assign w_tick       = r_baud == BAUD_LAST;
    assign w_push       = wr_en && (r_count != DEPTH);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (r_count != '0) ? S_START : S_IDLE;
            S_START:  w_next = w_tick ? S_DATA : S_START;
            S_DATA:   w_next = (w_tick && r_bit == BIT_LAST) ? AFTER_DATA : S_DATA;
            S_PARITY: w_next = w_tick ? S_STOP : S_PARITY;
            S_STOP:   w_next = w_tick ? ((r_count != '0) ? S_START : S_IDLE) : S_STOP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Stop-bit end pops straight into the next start bit so queued frames run back to back.
    always_comb begin
        w_pop       = (r_state == S_IDLE || (r_state == S_STOP && w_tick)) && (r_count != '0);
        w_bit_next  = (r_state == S_START) ? '0 :
                      (r_state == S_DATA && w_tick) ? r_bit + NW'(1) : r_bit;
        w_tx_next   = (w_next == S_START)  ? 1'b0 :
                      (w_next == S_DATA)   ? r_data[w_bit_next] :
                      (w_next == S_PARITY) ? ^r_data : 1'b1;
        w_busy_next = (w_next != S_IDLE) || (w_count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud     <= '0;
            r_bit      <= '0;
            r_data     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_baud     <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + BW'(1);
            r_bit      <= w_bit_next;
            if (w_pop) begin
                r_data <= r_mem[r_rptr];
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            r_count    <= w_count_next;
            r_full     <= w_count_next == DEPTH;
            r_overflow <= r_overflow | (wr_en & ~w_push);
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= wr_data;
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign fifo_full = r_full;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb_out_port_uart_tx: randomized scoreboard bench; a timeline model predicts frame starts and status,
// a line monitor decodes every frame from tx and checks it against the predicted queue.
module tb_out_port_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int FRAME  = (NB + 2) * CPB;
    localparam int STOP_J = CPB * (NB + 1) + 2;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx, busy, fifo_full, overflow;

    int cyc = 0, rst_cnt = 0, n_vec = 0, n_err = 0;

    logic [7:0] mq[$];
    exp_t       exp_q[$];
    int         frame_end = 0;
    bit         m_ovf = 0, m_busy = 0, m_full = 0, m_idle = 1, m_valid = 0;

    out_port_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rst_cnt <= rst_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: check the previous edge's outcome, drive inputs, then advance the model
    // to the edge about to happen (edge number cyc+1).
    task automatic step(input bit w, input logic [7:0] d, input bit r);
        int   e, n0;
        exp_t x;
        @(negedge clk);
        if (m_valid) begin
            chk("busy", busy, m_busy);
            chk("fifo_full", fifo_full, m_full);
            chk("overflow", overflow, m_ovf);
            if (m_idle) chk("tx_idle", tx, 1);
        end
        reset = r; wr_en = w; wr_data = d;
        e = cyc + 1;
        if (r) begin
            mq.delete();
            frame_end = 0;
            m_ovf = 0;
        end else begin
            n0 = mq.size();
            if (e >= frame_end && n0 > 0) begin
                x.data = mq.pop_front();
                x.start = e;
                exp_q.push_back(x);
                frame_end = e + FRAME;
            end
            if (w) begin
                if (n0 < DEPTH) mq.push_back(d);
                else m_ovf = 1;
            end
        end
        m_busy  = (e < frame_end) || (mq.size() > 0);
        m_full  = mq.size() == DEPTH;
        m_idle  = e >= frame_end;
        m_valid = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'h00, 0);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1, d, 0);
    endtask

    // Line monitor: samples each bit mid-cell; a reset inside a frame abandons it.
    initial begin
        exp_t       x;
        logic [7:0] got;
        logic       par, stp;
        int         s, rc;
        bit         ab, have;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                s = cyc; rc = rst_cnt; ab = 0; got = 8'h00; par = 1'b0; stp = 1'b0;
                have = exp_q.size() > 0;
                if (have) x = exp_q.pop_front();
                else begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_frame: start at cycle %0d, none predicted", s);
                end
                for (int j = 1; j <= STOP_J; j++) begin
                    @(negedge clk);
                    if (rst_cnt != rc) begin ab = 1; break; end
                    if (j >= 6 && j <= 34 && (j - 6) % CPB == 0) got[(j - 6) / CPB] = tx;
                    if (j == 38) par = tx;
                    if (j == STOP_J) stp = tx;
                end
                if (!ab && have) begin
                    chk("frame_start", s, x.start);
                    chk("frame_data", got, x.data);
                    chk("stop_bit", stp, 1);
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", par, ^x.data);
`endif
                end
            end
        end
    end

    initial begin
        int k;
        repeat (3) step(0, 8'h00, 1);
        wr(8'hA5); idle(50);
        wr(8'h07); idle(50);
        wr(8'h01); wr(8'h02); wr(8'h03); idle(130);
        for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
        idle(220);
        wr(8'hFF); wr(8'h3C); wr(8'hC3); idle(15);
        step(0, 8'h00, 1); idle(60);
        wr(8'hAA); idle(37); wr(8'h55); idle(90);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 999) == 0);
        k = 0;
        while ((mq.size() > 0 || cyc + 1 < frame_end) && k < 2000) begin
            step(0, 8'h00, 0);
            k++;
        end
        chk("drain_timeout", k < 2000, 1);
        idle(5);
        chk("frames_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
